write_pixels: RTL and testbench



---
 rtl/write_pixels.sv | 123 ++++++++++++
 tb/tb_write_pixels.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_pixels.sv
// write_pixels: TM1640-style two-wire serializer; turns one-byte write requests
// into start / LSB-first bytes / stop frames on sclk and din.
module write_pixels #(
   parameter int CLK_DIV = 6
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       valid,
   input  logic [7:0] pos,
   input  logic [7:0] value,
   output logic       sclk,
   output logic       din,
   output logic       busy
);
   localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   typedef enum logic [2:0] {IDLE, START, BIT_LO, BIT_HI, STOP0, STOP1, STOP2, GAP} state_t;
   state_t st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0] pos_q, pos_d, val_q, val_d;
   logic [2:0] bit_q, bit_d;
   logic byt_q, byt_d, frm_q, frm_d;
   logic sclk_q, sclk_d, din_q, din_d, busy_q, busy_d;
   logic tick, addr, last;
   logic [7:0] cur;
   assign tick = cnt_q == CW'(CLK_DIV - 1);
   assign addr = pos_q != 8'hFF;
   // an addressed request sends 0x44 alone, then a second frame of pos and value
   assign last = !(addr && frm_q) || byt_q;
   assign cur  = !addr ? val_q : !frm_q ? 8'h44 : byt_q ? val_q : pos_q;
   assign sclk = sclk_q;
   assign din  = din_q;
   assign busy = busy_q;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st_q   <= IDLE;
         cnt_q  <= '0;
         pos_q  <= 8'hFF;
         val_q  <= '0;
         bit_q  <= '0;
         byt_q  <= 1'b0;
         frm_q  <= 1'b0;
         sclk_q <= 1'b1;
         din_q  <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         pos_q  <= pos_d;
         val_q  <= val_d;
         bit_q  <= bit_d;
         byt_q  <= byt_d;
         frm_q  <= frm_d;
         sclk_q <= sclk_d;
         din_q  <= din_d;
         busy_q <= busy_d;
      end
   end
   always_comb begin
      st_d   = st_q;
      cnt_d  = (st_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
      pos_d  = pos_q;
      val_d  = val_q;
      bit_d  = bit_q;
      byt_d  = byt_q;
      frm_d  = frm_q;
      sclk_d = sclk_q;
      din_d  = din_q;
      busy_d = busy_q;
      if (st_q == IDLE) begin
         if (valid && !busy_q) begin
            st_d   = START;
            pos_d  = pos;
            val_d  = value;
            bit_d  = '0;
            byt_d  = 1'b0;
            frm_d  = 1'b0;
            busy_d = 1'b1;
         end
      end else if (tick) begin
         case (st_q)
            START: begin
               din_d = 1'b0;
               st_d  = BIT_LO;
            end
            BIT_LO: begin
               sclk_d = 1'b0;
               din_d  = cur[bit_q];
               st_d   = BIT_HI;
            end
            BIT_HI: begin
               sclk_d = 1'b1;
               bit_d  = bit_q + 3'd1;
               st_d   = (bit_q == 3'd7 && last) ? STOP0 : BIT_LO;
               if (bit_q == 3'd7) byt_d = !last;
            end
            STOP0: begin
               sclk_d = 1'b0;
               din_d  = 1'b0;
               st_d   = STOP1;
            end
            STOP1: begin
               sclk_d = 1'b1;
               st_d   = STOP2;
            end
            STOP2: begin
               din_d = 1'b1;
               st_d  = GAP;
            end
            GAP: begin
               if (addr && !frm_q) begin
                  frm_d = 1'b1;
                  byt_d = 1'b0;
                  st_d  = START;
               end else begin
                  st_d   = IDLE;
                  busy_d = 1'b0;
               end
            end
            default: st_d = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_write_pixels.sv
// tb_write_pixels: directed checks of framing, timing, lockout and divider for write_pixels.
module tb_write_pixels;
   logic clk = 1'b0;
   logic rst;
   logic v6, v1;
   logic [7:0] p6, x6, p1, x1;
   logic s6, d6, b6, s1, d1, b1;
   logic sel;
   logic s, d, b;
   int tests = 0;
   int fails = 0;
   logic bits[$];
   int rises[$];
   int busy_cnt, starts, stops, start_at;

   always #5 clk = ~clk;

   write_pixels #(.CLK_DIV(6)) dut6 (.CLK(clk), .RST(rst), .valid(v6), .pos(p6), .value(x6),
                                     .sclk(s6), .din(d6), .busy(b6));
   write_pixels #(.CLK_DIV(1)) dut1 (.CLK(clk), .RST(rst), .valid(v1), .pos(p1), .value(x1),
                                     .sclk(s1), .din(d1), .busy(b1));

   assign s = sel ? s1 : s6;
   assign d = sel ? d1 : d6;
   assign b = sel ? b1 : b6;

   function automatic logic [7:0] byte_at(input int k);
      logic [7:0] r;
      r = '0;
      for (int j = 0; j < 8; j++)
         if (8 * k + j < bits.size()) r[j] = bits[8 * k + j];
      return r;
   endfunction

   task automatic issue(input logic [7:0] p, input logic [7:0] x);
      if (sel) begin p1 = p; x1 = x; v1 = 1'b1; end
      else begin p6 = p; x6 = x; v6 = 1'b1; end
      @(negedge clk);
      v6 = 1'b0;
      v1 = 1'b0;
      tests++;
      if (b !== 1'b1) begin
         fails++;
         $display("FAIL busy_rise: busy=%b expected 1 one cycle after accept", b);
      end
   endtask

   task automatic collect(input int budget, input int lock_at);
      logic ps, pd;
      int n;
      ps = 1'b1; pd = 1'b1; n = 0;
      bits.delete(); rises.delete();
      starts = 0; stops = 0; start_at = -1;
      while (b && n < budget) begin
         if (s && !ps) begin bits.push_back(d); rises.push_back(n); end
         if (ps && s && pd && !d) begin starts++; if (start_at < 0) start_at = n; end
         if (ps && s && !pd && d) begin
            stops++;
            if (bits.size() > 0) begin void'(bits.pop_back()); void'(rises.pop_back()); end
         end
         if (sel) begin
            v1 = (n == lock_at);
            if (n == lock_at) begin p1 = 8'hFF; x1 = 8'h00; end
         end else begin
            v6 = (n == lock_at);
            if (n == lock_at) begin p6 = 8'hFF; x6 = 8'h00; end
         end
         ps = s; pd = d; n++;
         @(negedge clk);
      end
      v6 = 1'b0;
      v1 = 1'b0;
      busy_cnt = n;
      if (n >= budget) begin
         tests++; fails++;
         $display("FAIL timeout: busy still high after %0d cycles", n);
      end
   endtask

   task automatic test_reset;
      int bad;
      rst = 1'b1; v6 = 0; v1 = 0; p6 = 0; x6 = 0; p1 = 0; x1 = 0; sel = 1'b0;
      #1;
      tests++;
      if ({s6, d6, b6, s1, d1, b1} !== 6'b110110) begin
         fails++;
         $display("FAIL reset_idle: got %b expected 110110", {s6, d6, b6, s1, d1, b1});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if ({s6, d6, b6, s1, d1, b1} !== 6'b110110) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL idle_quiet: %0d non-idle samples, expected 0", bad);
      end
      issue(8'hFF, 8'h00);
      repeat (32) @(negedge clk);
      tests++;
      if ({s6, d6, b6} !== 3'b101) begin
         fails++;
         $display("FAIL mid_bit: got %b expected 101", {s6, d6, b6});
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({s6, d6, b6} !== 3'b110) begin
         fails++;
         $display("FAIL async_reset: got %b expected 110", {s6, d6, b6});
      end
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (15) begin
         @(negedge clk);
         if ({s6, d6, b6} !== 3'b110) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL post_reset_quiet: %0d non-idle samples, expected 0", bad);
      end
   endtask

   task automatic test_command;
      sel = 1'b0;
      issue(8'hFF, 8'h8F);
      collect(400, -1);
      tests++;
      if (busy_cnt != 126) begin
         fails++; $display("FAIL cmd_busy: %0d cycles expected 126", busy_cnt);
      end
      tests++;
      if (start_at != 6) begin
         fails++; $display("FAIL cmd_start_at: %0d expected 6", start_at);
      end
      tests++;
      if (bits.size() != 8 || byte_at(0) !== 8'h8F) begin
         fails++; $display("FAIL cmd_bits: %0d bits byte %h expected 8 bits 8f", bits.size(), byte_at(0));
      end
      tests++;
      if (starts != 1 || stops != 1) begin
         fails++; $display("FAIL cmd_frames: starts %0d stops %0d expected 1 1", starts, stops);
      end
   endtask

   task automatic test_addressed;
      sel = 1'b0;
      issue(8'hC3, 8'h99);
      collect(1000, -1);
      tests++;
      if (busy_cnt != 348) begin
         fails++; $display("FAIL addr_busy: %0d cycles expected 348", busy_cnt);
      end
      tests++;
      if (bits.size() != 24 || {byte_at(0), byte_at(1), byte_at(2)} !== 24'h44C399) begin
         fails++;
         $display("FAIL addr_bytes: %0d bits %h expected 24 bits 44c399", bits.size(),
                  {byte_at(0), byte_at(1), byte_at(2)});
      end
      tests++;
      if (starts != 2 || stops != 2) begin
         fails++; $display("FAIL addr_frames: starts %0d stops %0d expected 2 2", starts, stops);
      end
   endtask

   task automatic test_lockout;
      sel = 1'b0;
      issue(8'hC5, 8'h3C);
      collect(1000, 50);
      tests++;
      if (busy_cnt != 348 || {byte_at(0), byte_at(1), byte_at(2)} !== 24'h44C53C) begin
         fails++;
         $display("FAIL lockout: busy %0d bytes %h expected 348 44c53c", busy_cnt,
                  {byte_at(0), byte_at(1), byte_at(2)});
      end
      repeat (10) @(negedge clk);
      tests++;
      if (b6 !== 1'b0) begin
         fails++; $display("FAIL lockout_idle: busy %b expected 0", b6);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] x;
      sel = 1'b0;
      for (int i = 0; i < 16; i++) begin
         x = 8'(8'hF0 ^ i);
         issue(8'(8'hC0 + i), x);
         collect(1000, -1);
         tests++;
         if (busy_cnt != 348 || {byte_at(0), byte_at(1), byte_at(2)} !== {8'h44, 8'(8'hC0 + i), x}
             || starts != 2 || stops != 2) begin
            fails++;
            $display("FAIL b2b_%0d: busy %0d bytes %h frames %0d/%0d expected 348 %h 2/2", i, busy_cnt,
                     {byte_at(0), byte_at(1), byte_at(2)}, starts, stops, {8'h44, 8'(8'hC0 + i), x});
         end
      end
   endtask

   task automatic test_divider;
      int badp;
      sel = 1'b1;
      issue(8'hFF, 8'hA5);
      collect(200, -1);
      tests++;
      if (busy_cnt != 21 || start_at != 1) begin
         fails++; $display("FAIL div_timing: busy %0d start %0d expected 21 1", busy_cnt, start_at);
      end
      tests++;
      if (bits.size() != 8 || byte_at(0) !== 8'hA5) begin
         fails++; $display("FAIL div_bits: %0d bits byte %h expected 8 bits a5", bits.size(), byte_at(0));
      end
      badp = 0;
      for (int i = 1; i < rises.size(); i++)
         if (rises[i] - rises[i - 1] != 2) badp++;
      tests++;
      if (badp != 0 || rises.size() != 8) begin
         fails++; $display("FAIL div_period: %0d bad periods of %0d rises, expected 0 of 8", badp, rises.size());
      end
      issue(8'hFF, 8'h5A);
      collect(200, 20);
      @(negedge clk);
      tests++;
      if (busy_cnt != 21 || b1 !== 1'b0 || byte_at(0) !== 8'h5A) begin
         fails++;
         $display("FAIL clear_edge_valid: busy %0d now %b byte %h expected 21 0 5a", busy_cnt, b1, byte_at(0));
      end
   endtask

   initial begin
      test_reset;
      test_command;
      test_addressed;
      test_lockout;
      test_back_to_back;
      test_divider;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
